alu_seq_controller: RTL
=======================

ALU_SEQ_CONTROLLER -- requirements
Module: alu_seq_controller

Interface
REQ-001 Parameter DATA_W, default 32: operand/result width; legal values 8..64, even.
REQ-002 Parameter OP_W, default 4: width of Operation code.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 ALUOp  input  2: 00 LW/SW/AUIPC, 01 branch, 10 R-type/I-type, 11 JAL/LUI.
REQ-006 Funct7  input  7: instruction bits 31:25.
REQ-007 Funct3  input  3: instruction bits 14:12.
REQ-008 start_i  input  1: instruction valid this cycle.
REQ-009 srcA_i, srcB_i  input  DATA_W: operands, sampled at accepted start.
REQ-010 Operation  output  OP_W: single-cycle ALU operation select.
REQ-011 mext_o  output  1: current instruction is a sequenced M-extension op.
REQ-012 stall_o  output  1: pipeline must hold the instruction.
REQ-013 done_o  output  1: one-cycle pulse, result_o valid.
REQ-014 result_o  output  DATA_W: M-extension result, held until next accepted start.

Function
REQ-015 Operation SHALL be combinational from ALUOp/Funct3/Funct7 using package codes AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SRA 0110, SUB 0111, SLT 1000, SLTU 1001, EQ 1010, PASSB 1011.
REQ-016 ALUOp 00 -> ADD; 11 -> PASSB; 01 -> EQ for Funct3 000/001, SLT for 100/101, SLTU for 110/111.
REQ-017 ALUOp 10 decode by Funct3: 000 ADD (SUB if Funct7=0100000 and R-type), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if Funct7=0100000), 110 OR, 111 AND.
REQ-018 mext_o SHALL be 1 iff ALUOp=10 and Funct7=0000001; supported Funct3: 000 MUL, 011 MULHU, 101 DIVU, 111 REMU; other Funct3 with Funct7=0000001 -> mext_o=0, Operation=ADD.
REQ-019 FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-020 IDLE: start_i & mext_o -> capture operands and Funct3, load counter with DATA_W, go MUL (Funct3 0xx) or DIV (Funct3 1xx).
REQ-021 MUL: radix-2 shift-add into 2*DATA_W accumulator, one bit per cycle; counter decrements; at counter=1 go DONE.
REQ-022 DIV: restoring unsigned division, one quotient bit per cycle; at counter=1 go DONE.
REQ-023 DONE: result_o <= low half (MUL), high half (MULHU), quotient (DIVU) or remainder (REMU); done_o=1 for exactly this cycle; next state IDLE.
REQ-024 Latency: accepted start at cycle N -> done_o high at cycle N+DATA_W+1.
REQ-025 stall_o = (start_i & mext_o & state==IDLE) | (state!=IDLE & state!=DONE); stall_o=0 in DONE.
REQ-026 start_i while state!=IDLE SHALL be ignored; no operand re-capture.
REQ-027 Divide by zero: DIVU -> all ones, REMU -> srcA; full latency still applies.
REQ-028 Non-M start_i SHALL not change state, stall_o, or result_o.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, counter 0, accumulators 0, result_o 0, done_o 0, stall_o 0 except its combinational start term.
REQ-030 Reset mid-operation SHALL abandon the operation with no done_o pulse.

Structure
REQ-031 Package alu_ctrl_pkg SHALL hold the OP_W operation codes, ALUOp codes, Funct7 constants (BASE, ALT, MEXT), and the FSM state enum.
REQ-032 Sub-module alu_muldiv_iter SHALL contain the FSM, counter and datapath; alu_seq_controller SHALL hold decode and instance it.

Verification (DATA_W=32)
REQ-033 ALUOp=10, Funct3=000, Funct7=0100000 -> Operation=0111, mext_o=0, stall_o=0.
REQ-034 MUL 0x0001_0003 x 0x0000_0005 at cycle 0 -> stall_o cycles 0..32, done_o at cycle 33, result_o=0x0005_000F.
REQ-035 MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> result_o=0xFFFF_FFFE.
REQ-036 DIVU 100/7 -> 0x0000_000E; REMU 100/7 -> 0x0000_0002; DIVU 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 0x0000_0005.
REQ-037 Second start_i at cycle 10 of a DIVU -> ignored, first result unchanged, one done_o only.
REQ-038 rst_n low at cycle 15 of a MUL -> state IDLE immediately, result_o=0, no done_o; new MUL then completes normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU operation codes, decode constants and sequencer state type
package alu_ctrl_pkg;

   localparam int OP_CODE_W = 4;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_SLL   = 4'b0100;
   localparam logic [3:0] OP_SRL   = 4'b0101;
   localparam logic [3:0] OP_SRA   = 4'b0110;
   localparam logic [3:0] OP_SUB   = 4'b0111;
   localparam logic [3:0] OP_SLT   = 4'b1000;
   localparam logic [3:0] OP_SLTU  = 4'b1001;
   localparam logic [3:0] OP_EQ    = 4'b1010;
   localparam logic [3:0] OP_PASSB = 4'b1011;

   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_ARITH = 2'b10;
   localparam logic [1:0] ALUOP_JUMP  = 2'b11;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   localparam logic [2:0] F3_MUL   = 3'b000;
   localparam logic [2:0] F3_MULHU = 3'b011;
   localparam logic [2:0] F3_DIVU  = 3'b101;
   localparam logic [2:0] F3_REMU  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   function automatic logic is_seq_f3(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULHU) || (f3 == F3_DIVU) || (f3 == F3_REMU);
   endfunction

endpackage

// File: rtl/alu_seq_controller_if.sv
// rtl/alu_seq_controller_if.sv - start/operand/result handshake between pipeline and sequencer
interface alu_seq_controller_if #(
   parameter int DATA_W = 32
) ();
   logic              start_i;
   logic [DATA_W-1:0] srcA_i;
   logic [DATA_W-1:0] srcB_i;
   logic              stall_o;
   logic              done_o;
   logic [DATA_W-1:0] result_o;

   modport master (
      output start_i, srcA_i, srcB_i,
      input  stall_o, done_o, result_o
   );

   modport slave (
      input  start_i, srcA_i, srcB_i,
      output stall_o, done_o, result_o
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - bit-serial unsigned multiply / restoring divide sequencer
module alu_muldiv_iter
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mext,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] srca,
   input  logic [DATA_W-1:0] srcb,
   output logic              stall,
   output logic              done,
   output logic [DATA_W-1:0] result
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   opa;
   logic [2*DATA_W-1:0] acc;
   logic [2:0]          f3_q;
   logic                accept;
   logic                last_step;

   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W:0]     div_diff;
   logic [2*DATA_W-1:0] mul_acc;
   logic [2*DATA_W-1:0] div_acc;
   logic [2*DATA_W-1:0] step_acc;
   logic [DATA_W-1:0]   res_sel;

   assign accept    = start && mext && (state == ST_IDLE);
   assign last_step = (cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               stall     = 1'b1;
               state_nxt = funct3[2] ? ST_DIV : ST_MUL;
            end
         end
         ST_MUL, ST_DIV: begin
            stall = 1'b1;
            if (last_step) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // acc = {partial product | remainder, multiplier | quotient}; both algorithms shift one bit per cycle
   always_comb begin
      mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opa} : '0);
      mul_acc   = {mul_sum, acc[DATA_W-1:1]};
      div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
      div_diff  = div_shift - {1'b0, opa};
      div_acc   = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                   : {div_diff[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};
      step_acc  = (state == ST_DIV) ? div_acc : mul_acc;
      res_sel   = ((f3_q == F3_MULHU) || (f3_q == F3_REMU)) ? step_acc[2*DATA_W-1:DATA_W]
                                                            : step_acc[DATA_W-1:0];
   end

   // result is loaded on the final step so it is already valid while done is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         opa    <= '0;
         acc    <= '0;
         f3_q   <= '0;
         result <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  f3_q <= funct3;
                  cnt  <= CNT_W'(DATA_W);
                  if (funct3[2]) begin
                     opa <= srcb;
                     acc <= {{DATA_W{1'b0}}, srca};
                  end else begin
                     opa <= srca;
                     acc <= {{DATA_W{1'b0}}, srcb};
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               acc <= step_acc;
               cnt <= cnt - CNT_W'(1);
               if (last_step) result <= res_sel;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu_seq_controller.sv
// rtl/alu_seq_controller.sv - ALU operation decode with sequenced M-extension unit
module alu_seq_controller
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          ALUOp,
   input  logic [6:0]          Funct7,
   input  logic [2:0]          Funct3,
   output logic [OP_W-1:0]     Operation,
   output logic                mext_o,
   alu_seq_controller_if.slave bus
);
   logic [OP_CODE_W-1:0] op;

   assign mext_o = (ALUOp == ALUOP_ARITH) && (Funct7 == F7_MEXT) && is_seq_f3(Funct3);

   always_comb begin
      op = OP_ADD;
      case (ALUOp)
         ALUOP_MEM:  op = OP_ADD;
         ALUOP_JUMP: op = OP_PASSB;
         ALUOP_BR: begin
            case (Funct3[2:1])
               2'b10:   op = OP_SLT;
               2'b11:   op = OP_SLTU;
               default: op = OP_EQ;
            endcase
         end
         ALUOP_ARITH: begin
            // M-extension encodings keep the datapath on ADD; the sequencer owns the result
            if (Funct7 == F7_MEXT) begin
               op = OP_ADD;
            end else begin
               case (Funct3)
                  3'b000:  op = (Funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                  3'b001:  op = OP_SLL;
                  3'b010:  op = OP_SLT;
                  3'b011:  op = OP_SLTU;
                  3'b100:  op = OP_XOR;
                  3'b101:  op = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                  3'b110:  op = OP_OR;
                  default: op = OP_AND;
               endcase
            end
         end
         default: op = OP_ADD;
      endcase
   end

   assign Operation = OP_W'(op);

   alu_muldiv_iter #(
      .DATA_W (DATA_W)
   ) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (bus.start_i),
      .mext   (mext_o),
      .funct3 (Funct3),
      .srca   (bus.srcA_i),
      .srcb   (bus.srcB_i),
      .stall  (bus.stall_o),
      .done   (bus.done_o),
      .result (bus.result_o)
   );

endmodule
